stream_merge2: RTL and testbench

- Two-input round-robin stream merger with a valid/ready handshake on every channel.
- Sits directly upstream of the 2:1 mux stage and feeds it: each forwarded beat comes with a registered `sel` that tells the mux which source it came from (0 = a, 1 = b).
- Packets are indivisible. Once a source is granted, it keeps the output until its `last` beat is accepted.
- A single output register decouples upstream timing from downstream timing.

---
 rtl/stream_merge2.sv | 101 ++++++++++
 tb/tb_stream_merge2.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/stream_merge2.sv
// rtl/stream_merge2.sv - two-input round-robin packet merger with registered output and source tag
module stream_merge2 #(
  parameter int W  = 8,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [W-1:0]  a_data,
  input  logic          a_last,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [W-1:0]  b_data,
  input  logic          b_last,
  output logic          sel,
  output logic          y_valid,
  input  logic          y_ready,
  output logic [W-1:0]  y_data,
  output logic          y_last,
  output logic [CW-1:0] pkt_cnt
);

  typedef enum logic [1:0] {IDLE, LOCK_A, LOCK_B} state_t;

  state_t state, state_nxt;
  logic   prio, prio_nxt;
  logic   load_en;
  logic   grant_a, grant_b;
  logic   take_a, take_b, take, take_last;

  assign load_en = !y_valid || y_ready;

  // A locked source keeps the grant even while its valid is low.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    case (state)
      IDLE: begin
        if (a_valid && (!b_valid || !prio)) grant_a = 1'b1;
        else if (b_valid)                   grant_b = 1'b1;
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: ;
    endcase
  end

  assign a_ready   = rst_n && load_en && grant_a;
  assign b_ready   = rst_n && load_en && grant_b;
  assign take_a    = a_valid && a_ready;
  assign take_b    = b_valid && b_ready;
  assign take      = take_a || take_b;
  assign take_last = take_a ? a_last : b_last;

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    if (take) begin
      if (take_last) begin
        state_nxt = IDLE;
        prio_nxt  = take_a;
      end else begin
        state_nxt = take_a ? LOCK_A : LOCK_B;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_valid <= 1'b0;
      y_data  <= '0;
      y_last  <= 1'b0;
      sel     <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      if (load_en) begin
        if (take) begin
          y_data  <= take_a ? a_data : b_data;
          y_last  <= take_last;
          sel     <= take_b;
          y_valid <= 1'b1;
        end else begin
          y_valid <= 1'b0;
        end
      end
      if (take && take_last) pkt_cnt <= pkt_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_stream_merge2.sv
// tb/tb_stream_merge2.sv - directed self-checking bench for stream_merge2
module tb_stream_merge2;

  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_last, b_valid, b_last, y_ready;
  logic [W-1:0]  a_data, b_data;
  logic          a_ready, b_ready, sel, y_valid, y_last;
  logic [W-1:0]  y_data;
  logic [CW-1:0] pkt_cnt;

  int checks   = 0;
  int failures = 0;

  stream_merge2 #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_last(b_last),
    .sel(sel), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_last(y_last), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_y(input string tag, input logic [7:0] d, input logic s,
                         input logic l, input logic [1:0] c);
    check({tag, "_valid"}, 32'(y_valid), 32'd1);
    check({tag, "_data"},  32'(y_data),  32'(d));
    check({tag, "_sel"},   32'(sel),     32'(s));
    check({tag, "_last"},  32'(y_last),  32'(l));
    check({tag, "_cnt"},   32'(pkt_cnt), 32'(c));
  endtask

  initial begin
    rst_n = 1'b0; y_ready = 1'b1;
    a_valid = 1'b1; a_data = 8'h00; a_last = 1'b0;
    b_valid = 1'b1; b_data = 8'h00; b_last = 1'b0;
    step(); step(); step();
    check("rst_y_valid", 32'(y_valid), 32'd0);
    check("rst_sel",     32'(sel),     32'd0);
    check("rst_cnt",     32'(pkt_cnt), 32'd0);
    check("rst_a_ready", 32'(a_ready), 32'd0);
    check("rst_b_ready", 32'(b_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_a_ready", 32'(a_ready), 32'd1);
    check("rel_b_ready", 32'(b_ready), 32'd0);
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check("idle_y_valid", 32'(y_valid), 32'd0);

    // single 3-beat packet from A
    a_valid = 1'b1; a_data = 8'h11; a_last = 1'b0;
    #1 check("sa_a_ready", 32'(a_ready), 32'd1);
    step(); check_y("sa1", 8'h11, 1'b0, 1'b0, 2'd0);
    a_data = 8'h22;
    step(); check_y("sa2", 8'h22, 1'b0, 1'b0, 2'd0);
    a_data = 8'h33; a_last = 1'b1;
    step(); check_y("sa3", 8'h33, 1'b0, 1'b1, 2'd1);
    a_valid = 1'b0;
    step();
    check("drain_valid", 32'(y_valid), 32'd0);
    check("drain_hold",  32'(y_data),  32'h33);

    // round-robin with single-beat packets; prio now favours B
    a_valid = 1'b1; a_data = 8'hAA; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'hBB; b_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_a_ready", 32'(a_ready), (i % 2 == 1) ? 32'd1 : 32'd0);
      check("rr_b_ready", 32'(b_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      step();
      check_y("rr", (i % 2 == 0) ? 8'hBB : 8'hAA, (i % 2 == 0), 1'b1, 2'((2 + i) % 4));
    end

    // packet lock: A holds the output for 4 beats while B waits
    b_valid = 1'b0;
    a_data = 8'h01; a_last = 1'b0;
    step(); check_y("lk1", 8'h01, 1'b0, 1'b0, 2'd1);
    b_valid = 1'b1; b_data = 8'hB1; b_last = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      a_data = 8'(i); a_last = (i == 4);
      #1;
      check("lk_b_ready", 32'(b_ready), 32'd0);
      check("lk_a_ready", 32'(a_ready), 32'd1);
      step();
      check_y("lk", 8'(i), 1'b0, (i == 4), (i == 4) ? 2'd2 : 2'd1);
    end
    a_valid = 1'b0;
    #1 check("lk_b_grant", 32'(b_ready), 32'd1);
    step(); check_y("lk_b", 8'hB1, 1'b1, 1'b1, 2'd3);

    // backpressure
    b_valid = 1'b0;
    a_valid = 1'b1; a_data = 8'h55; a_last = 1'b1;
    step(); check_y("bp0", 8'h55, 1'b0, 1'b1, 2'd0);
    y_ready = 1'b0; a_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_a_ready", 32'(a_ready), 32'd0);
      check("bp_b_ready", 32'(b_ready), 32'd0);
      step();
      check_y("bp_hold", 8'h55, 1'b0, 1'b1, 2'd0);
    end
    y_ready = 1'b1;
    #1 check("bp_resume", 32'(a_ready), 32'd1);
    step(); check_y("bp1", 8'h66, 1'b0, 1'b1, 2'd1);
    a_valid = 1'b0;
    step(); check("bp_drain", 32'(y_valid), 32'd0);

    // reset mid-packet from B
    b_valid = 1'b1; b_data = 8'h71; b_last = 1'b0;
    step(); check_y("mr1", 8'h71, 1'b1, 1'b0, 2'd1);
    b_data = 8'h72;
    step(); check_y("mr2", 8'h72, 1'b1, 1'b0, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mr_y_valid", 32'(y_valid), 32'd0);
    check("mr_sel",     32'(sel),     32'd0);
    check("mr_cnt",     32'(pkt_cnt), 32'd0);
    check("mr_b_ready", 32'(b_ready), 32'd0);
    step();
    rst_n = 1'b1;
    a_valid = 1'b1; a_data = 8'hAA; a_last = 1'b1;
    b_valid = 1'b1; b_data = 8'hBB; b_last = 1'b1;
    #1;
    check("mr_a_first", 32'(a_ready), 32'd1);
    check("mr_b_wait",  32'(b_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check_y("wrap", (i % 2 == 0) ? 8'hAA : 8'hBB, (i % 2 == 1), 1'b1, 2'((i + 1) % 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
